// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - decode/issue stage with register file, pending-write scoreboard and one-entry issue slot
// Optional macro ID_WB_BYPASS_EN: same-cycle write-back bypass into hazard check and operand read.
module id_scoreboard #(
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [ADDR_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0]   i_instr,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic                 i_rs1_en,
  input  logic                 i_rs2_en,
  input  logic                 i_rd_en,
  input  logic                 i_flush,
  input  logic                 i_wb_en,
  input  logic [REG_IDX_W-1:0] i_wb_reg,
  input  logic [WORD_W-1:0]    i_wb_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ADDR_W-1:0]    o_pc,
  output logic [INSTR_W-1:0]   o_instr,
  output logic [WORD_W-1:0]    o_rs1_data,
  output logic [WORD_W-1:0]    o_rs2_data,
  output logic [REG_IDX_W-1:0] o_rd,
  output logic                 o_rd_en
);

  localparam int NREGS = 2 ** REG_IDX_W;
`ifdef ID_WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [WORD_W-1:0]    rf_q [NREGS];
  logic [NREGS-1:0]     pend_q, pend_d, pend_eff;

  logic                 valid_q, valid_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [WORD_W-1:0]    rs1_data_q, rs1_data_d;
  logic [WORD_W-1:0]    rs2_data_q, rs2_data_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 rd_en_q, rd_en_d;

  logic                 wb_hit, hazard, ready, accept, rd_en_in;
  logic [WORD_W-1:0]    rs1_val, rs2_val;

  assign wb_hit   = i_wb_en && (i_wb_reg != '0);
  assign rd_en_in = i_rd_en && (i_rd != '0);

  // A pending register whose write-back arrives this cycle is released early only with the bypass.
  always_comb begin
    pend_eff = pend_q;
    if (BYPASS && wb_hit) pend_eff[i_wb_reg] = 1'b0;
  end

  assign hazard = (i_rs1_en && (i_rs1 != '0) && pend_eff[i_rs1]) ||
                  (i_rs2_en && (i_rs2 != '0) && pend_eff[i_rs2]) ||
                  (i_rd_en  && (i_rd  != '0) && pend_eff[i_rd]);
  assign ready  = !hazard && !i_flush && (!valid_q || i_ready);
  assign accept = i_valid && ready;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (i_rs1_en && (i_rs1 != '0)) begin
      if (BYPASS && wb_hit && (i_wb_reg == i_rs1)) rs1_val = i_wb_data;
      else                                         rs1_val = rf_q[i_rs1];
    end
    if (i_rs2_en && (i_rs2 != '0)) begin
      if (BYPASS && wb_hit && (i_wb_reg == i_rs2)) rs2_val = i_wb_data;
      else                                         rs2_val = rf_q[i_rs2];
    end
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rd_d       = rd_q;
    rd_en_d    = rd_en_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      pc_d       = i_pc;
      instr_d    = i_instr;
      rs1_data_d = rs1_val;
      rs2_data_d = rs2_val;
      rd_d       = i_rd;
      rd_en_d    = rd_en_in;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Clears first so a new writer's set wins on the same index.
  always_comb begin
    pend_d = pend_q;
    if (wb_hit) pend_d[i_wb_reg] = 1'b0;
    if (i_flush && valid_q && rd_en_q) pend_d[rd_q] = 1'b0;
    if (accept && rd_en_in) pend_d[i_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_q       <= '0;
      rd_en_q    <= 1'b0;
      pend_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_q       <= rd_d;
      rd_en_q    <= rd_en_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else if (wb_hit) begin
      rf_q[i_wb_reg] <= i_wb_data;
    end
  end

  assign o_ready    = ready;
  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_instr    = instr_q;
  assign o_rs1_data = rs1_data_q;
  assign o_rs2_data = rs2_data_q;
  assign o_rd       = rd_q;
  assign o_rd_en    = rd_en_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed and randomized checks of id_scoreboard against a behavioural model
module tb_id_scoreboard;
`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        i_valid, o_ready;
  logic [31:0] i_pc, i_instr;
  logic [4:0]  i_rs1, i_rs2, i_rd;
  logic        i_rs1_en, i_rs2_en, i_rd_en;
  logic        i_flush;
  logic        i_wb_en;
  logic [4:0]  i_wb_reg;
  logic [31:0] i_wb_data;
  logic        o_valid, i_ready;
  logic [31:0] o_pc, o_instr, o_rs1_data, o_rs2_data;
  logic [4:0]  o_rd;
  logic        o_rd_en;

  id_scoreboard dut (
    .clk(clk), .clr(clr), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_instr(i_instr),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_rs1_en(i_rs1_en), .i_rs2_en(i_rs2_en), .i_rd_en(i_rd_en),
    .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_instr(o_instr), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rd(o_rd), .o_rd_en(o_rd_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic got_ready;

  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_valid, m_rd_en;
  logic [31:0] m_pc, m_instr, m_op1, m_op2;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit blocks(input logic [4:0] idx, input logic en);
    if (!en || idx == 0 || !m_pend[idx]) return 1'b0;
    if (BYP && i_wb_en && i_wb_reg == idx) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready();
    if (blocks(i_rs1, i_rs1_en) || blocks(i_rs2, i_rs2_en) || blocks(i_rd, i_rd_en)) return 1'b0;
    if (i_flush) return 1'b0;
    return !m_valid || i_ready;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic en);
    if (!en || idx == 0) return 32'h0;
    if (BYP && i_wb_en && i_wb_reg == idx) return i_wb_data;
    return m_rf[idx];
  endfunction

  task automatic model_edge(input bit rdy);
    bit acc;
    if (clr) begin
      for (int r = 0; r < 32; r++) begin m_rf[r] = 0; m_pend[r] = 0; end
      m_valid = 0; m_pc = 0; m_instr = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_en = 0;
      return;
    end
    acc = i_valid && rdy;
    if (i_wb_en && i_wb_reg != 0) m_pend[i_wb_reg] = 0;
    if (i_flush && m_valid && m_rd_en) m_pend[m_rd] = 0;
    if (acc && i_rd_en && i_rd != 0) m_pend[i_rd] = 1;
    if (i_flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_pc = i_pc; m_instr = i_instr;
      m_op1 = model_read(i_rs1, i_rs1_en);
      m_op2 = model_read(i_rs2, i_rs2_en);
      m_rd = i_rd; m_rd_en = i_rd_en && i_rd != 0;
    end else if (i_ready) m_valid = 0;
    if (i_wb_en && i_wb_reg != 0) m_rf[i_wb_reg] = i_wb_data;
  endtask

  // Inputs are set at the falling edge before each call.
  task automatic step();
    bit r;
    #1;
    r = model_ready();
    got_ready = o_ready;
    check("ready", o_ready, r);
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check("valid", o_valid, m_valid);
    check("pc", o_pc, m_pc);
    check("instr", o_instr, m_instr);
    check("rs1_data", o_rs1_data, m_op1);
    check("rs2_data", o_rs2_data, m_op2);
    check("rd", o_rd, m_rd);
    check("rd_en", o_rd_en, m_rd_en);
  endtask

  task automatic idle();
    clr = 0; i_valid = 0; i_pc = 0; i_instr = 0;
    i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_rs1_en = 0; i_rs2_en = 0; i_rd_en = 0;
    i_flush = 0; i_wb_en = 0; i_wb_reg = 0; i_wb_data = 0; i_ready = 1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    clr = 1; step(); step();
    check("reset_valid", o_valid, 0);
    check("reset_pc", o_pc, 0);
    idle();

    // write-back then dependent read
    i_wb_en = 1; i_wb_reg = 5; i_wb_data = 32'h1234; step(); idle();
    check("first_ready", got_ready, 1);
    i_valid = 1; i_pc = 32'h10; i_rs1 = 5; i_rs1_en = 1; step(); idle();
    check("wb_read_valid", o_valid, 1);
    check("wb_read_data", o_rs1_data, 32'h1234);

    // RAW stall on r3 until its write-back
    i_valid = 1; i_pc = 32'h20; i_rd = 3; i_rd_en = 1; step(); idle();
    i_valid = 1; i_pc = 32'h24; i_rs2 = 3; i_rs2_en = 1;
    step(); check("raw_stall0", got_ready, 0);
    step(); check("raw_stall1", got_ready, 0);
    i_wb_en = 1; i_wb_reg = 3; i_wb_data = 32'hAA;
    step(); check("raw_wb_cycle", got_ready, BYP);
    i_wb_en = 0;
    if (!BYP) begin step(); check("raw_after_wb", got_ready, 1); end
    check("raw_data", o_rs2_data, 32'hAA);
    idle(); step();

    // backpressure hold
    i_valid = 1; i_pc = 32'h100; i_instr = 32'hDEAD; step();
    i_ready = 0; i_pc = 32'h200; i_instr = 32'hBEEF;
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_ready", got_ready, 0);
      check("hold_pc", o_pc, 32'h100);
    end
    i_ready = 1; step();
    check("release_ready", got_ready, 1);
    check("release_pc", o_pc, 32'h200);
    idle(); step();

    // flush releases pending destination
    i_valid = 1; i_pc = 32'h300; i_rd = 7; i_rd_en = 1; step(); idle();
    i_ready = 0; i_flush = 1; step(); idle();
    check("flush_valid", o_valid, 0);
    i_valid = 1; i_pc = 32'h304; i_rs1 = 7; i_rs1_en = 1; step(); idle();
    check("flush_r7_ready", got_ready, 1);

    // r0 is never pending and always reads zero
    i_valid = 1; i_pc = 32'h400; i_rd = 0; i_rd_en = 1; step(); idle();
    check("r0_rd_en", o_rd_en, 0);
    i_valid = 1; i_pc = 32'h404; i_rs1 = 0; i_rs1_en = 1;
    i_wb_en = 1; i_wb_reg = 0; i_wb_data = 32'hFF; step(); idle();
    check("r0_ready", got_ready, 1);
    check("r0_data", o_rs1_data, 0);

    // reset while stalled
    i_valid = 1; i_pc = 32'h500; i_rd = 9; i_rd_en = 1; step(); idle();
    i_ready = 0; i_valid = 1; i_pc = 32'h504; i_rs1 = 9; i_rs1_en = 1; step();
    check("stall_r9", got_ready, 0);
    clr = 1; step(); clr = 0;
    check("clr_valid", o_valid, 0);
    check("clr_pc", o_pc, 0);
    step();
    check("clr_release_ready", got_ready, 1);
    idle();

    for (int n = 0; n < 3000; n++) begin
      clr       = ($urandom_range(0, 299) == 0);
      i_valid   = ($urandom_range(0, 3) != 0);
      i_pc      = $urandom; i_instr = $urandom;
      i_rs1     = 5'($urandom_range(0, 7)); i_rs1_en = 1'($urandom_range(0, 1));
      i_rs2     = 5'($urandom_range(0, 7)); i_rs2_en = 1'($urandom_range(0, 1));
      i_rd      = 5'($urandom_range(0, 7)); i_rd_en  = 1'($urandom_range(0, 1));
      i_flush   = ($urandom_range(0, 15) == 0);
      i_wb_en   = ($urandom_range(0, 9) < 4);
      i_wb_reg  = 5'($urandom_range(0, 7));
      i_wb_data = $urandom;
      i_ready   = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
